i2c_cmd_arbiter: RTL and testbench
==================================

Name: i2c_cmd_arbiter

Overview:
- Shares the single codec I2C command interface (i2c_address/i2c_data/interface_enable/interface_acknowledge) between two requesters.
- Requester 0 is the power-up register sequencer. Requester 1 is the runtime controller (volume and mute writes).
- Each accepted command is latched, issued on the master's acknowledge rising edge, and retired on its falling edge, with a timeout watchdog.
- Requester 1 is locked out until cfg_complete is asserted.

Parameters:
- TO_WIDTH, 18, width of the watchdog counter. Timeout fires when the counter reaches 2^TO_WIDTH-1 (262143 cycles, about 5.2 ms at 50 MHz).

Ports:
- clk50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low reset (0 = reset)
- cfg_complete  in  1  level; high enables arbitration for requester 1
- req0_valid  in  1  requester 0 has a command
- req0_address  in  16  requester 0 register address
- req0_data  in  16  requester 0 register data
- req0_ready  out  1  1-cycle pulse: requester 0 command accepted and latched
- req0_done  out  1  1-cycle pulse: requester 0 command retired
- req1_valid, req1_address, req1_data, req1_ready, req1_done  as requester 0, for requester 1
- req_err  out  1  1-cycle pulse coincident with reqN_done when the retire was a timeout
- i2c_address  out  16  latched address to the I2C master
- i2c_data  out  16  latched data to the I2C master
- interface_enable  out  1  1-cycle issue strobe to the I2C master
- interface_acknowledge  in  1  master handshake: rise = ready for command, fall = transaction complete
- busy  out  1  high from accept until retire
- owner  out  1  index of the current or last granted requester

Behaviour:
- Reset (reset==0 at a clk50 edge):
  - All outputs go to 0; i2c_address and i2c_data go to 16'h0000.
  - State goes to IDLE, watchdog clears, rr_last goes to 1 (so requester 0 wins the first tie).
  - ack_q goes to 1, so a high acknowledge present at reset release is not a rising edge.
  - Reset mid-transaction aborts silently: no done or err pulse, and no further enable.
- Edge detection:
  - ack_q registers interface_acknowledge every cycle.
  - rise = ack & ~ack_q; fall = ~ack & ack_q.
- Eligibility: e0 = req0_valid; e1 = req1_valid & cfg_complete.
- IDLE:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to rr_last (round-robin).
  - On grant, in the same edge: latch reqN_address/reqN_data into i2c_address/i2c_data, pulse reqN_ready, set owner and rr_last, set busy=1, clear the watchdog, go to WAIT_RISE.
  - Acknowledge edges seen in IDLE are ignored.
- WAIT_RISE:
  - On rise: pulse interface_enable for exactly one cycle (the cycle after rise is observed), clear the watchdog, go to WAIT_FALL.
- WAIT_FALL:
  - On fall: go to RETIRE.
  - A second rise before fall is ignored; no re-issue.
- RETIRE (1 cycle):
  - Pulse reqN_done for the owner, busy=0, go to IDLE.
  - A new grant can occur on the next cycle, so back-to-back accepts are spaced at least 1 idle cycle apart.
- Watchdog:
  - Increments in WAIT_RISE and WAIT_FALL, and saturates.
  - At all-ones: go to RETIRE with req_err=1 in the done cycle.
  - If fall and timeout occur in the same cycle, fall wins (req_err=0).
- Address/data:
  - i2c_address and i2c_data hold their latched values from accept through retire and afterwards, until the next grant.
  - Requester inputs may change after the ready pulse.
- Lockout:
  - cfg_complete dropping while requester 1 owns the bus does not abort that transaction; it only blocks future grants.
- Latency: accept-to-issue is (cycles until rise) + 1. Fall-to-done is 2 cycles.
- Exactly one interface_enable is produced per accepted command, or zero on timeout before rise. Never more than one.

Test Plan:
- Accept/issue/retire:
  - Stimulus: cfg_complete=0, req0_valid with addr 16'h0032, data 16'h739b; ack rises 10 cycles later and falls 200 cycles later.
  - Required: one req0_ready; i2c_address/i2c_data = 0032/739b; one interface_enable 1 cycle after the rise; req0_done 2 cycles after the fall; req_err=0.
- Lockout:
  - Stimulus: req1_valid with 16'h0022/16'h5a5a while cfg_complete=0 for 500 cycles, then cfg_complete=1.
  - Required: no req1_ready before cfg_complete; req1_ready the cycle after cfg_complete rises.
- Round-robin:
  - Stimulus: cfg_complete=1, both requesters valid continuously for 4 transactions.
  - Required: grant order 0,1,0,1; owner tracks each grant; each command gets exactly one enable.
- Timeout:
  - Stimulus: TO_WIDTH=4, accept a command, hold ack low.
  - Required: no interface_enable; done with req_err=1 after 15 watchdog cycles; then IDLE and the next request is accepted.
- Reset mid-transaction:
  - Stimulus: drive reset=0 for 1 cycle while in WAIT_FALL.
  - Required: all outputs 0 the next cycle; no done or err pulse.
  - Stimulus: a later ack fall with no pending request.
  - Required: no response.
- Spurious edges:
  - Stimulus: ack toggles while IDLE; a double rise in WAIT_FALL.
  - Required: no enable while IDLE; a single enable per command.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one codec I2C command port between the power-up
// sequencer (requester 0) and the runtime controller (requester 1).
// A command is latched on accept, issued on the acknowledge rising edge,
// retired on its falling edge. A saturating watchdog forces the retire if
// the master never answers.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no command held; arbitrate between eligible requesters
// WAIT_RISE  | command latched, waiting for the master to become ready
// WAIT_FALL  | command issued, waiting for the transaction to complete
// RETIRE     | one cycle; emit done (and err on timeout) for the owner
module i2c_cmd_arbiter #(
  parameter int TO_WIDTH = 18
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        cfg_complete,
  input  logic        req0_valid,
  input  logic [15:0] req0_address,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [15:0] req1_address,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req_err,
  output logic [15:0] i2c_address,
  output logic [15:0] i2c_data,
  output logic        interface_enable,
  input  logic        interface_acknowledge,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    RETIRE    = 2'd3
  } state_t;

  state_t              state;
  logic                ack_q;
  logic [TO_WIDTH-1:0] wd;
  logic                rr_last;
  logic                err_pend;

  logic ack_rise;
  logic ack_fall;
  logic elig0;
  logic elig1;
  logic grant1;
  logic wd_max;

  assign ack_rise = interface_acknowledge & ~ack_q;
  assign ack_fall = ~interface_acknowledge & ack_q;
  assign elig0    = req0_valid;
  assign elig1    = req1_valid & cfg_complete;
  // On a tie the requester that did not win last time gets the grant.
  assign grant1   = elig1 & (~elig0 | ~rr_last);
  assign wd_max   = &wd;

  // Arbitration, handshake sequencing, watchdog and all registered outputs.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      state            <= IDLE;
      ack_q            <= 1'b1;
      wd               <= '0;
      rr_last          <= 1'b1;
      err_pend         <= 1'b0;
      req0_ready       <= 1'b0;
      req0_done        <= 1'b0;
      req1_ready       <= 1'b0;
      req1_done        <= 1'b0;
      req_err          <= 1'b0;
      i2c_address      <= 16'h0000;
      i2c_data         <= 16'h0000;
      interface_enable <= 1'b0;
      busy             <= 1'b0;
      owner            <= 1'b0;
    end else begin
      ack_q            <= interface_acknowledge;
      req0_ready       <= 1'b0;
      req1_ready       <= 1'b0;
      req0_done        <= 1'b0;
      req1_done        <= 1'b0;
      req_err          <= 1'b0;
      interface_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            owner       <= grant1;
            rr_last     <= grant1;
            i2c_address <= grant1 ? req1_address : req0_address;
            i2c_data    <= grant1 ? req1_data : req0_data;
            req0_ready  <= ~grant1;
            req1_ready  <= grant1;
            busy        <= 1'b1;
            wd          <= '0;
            err_pend    <= 1'b0;
            state       <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (ack_rise) begin
            interface_enable <= 1'b1;
            wd               <= '0;
            state            <= WAIT_FALL;
          end else if (wd_max) begin
            err_pend <= 1'b1;
            state    <= RETIRE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        WAIT_FALL: begin
          // A completed transaction beats a simultaneous timeout.
          if (ack_fall) begin
            state <= RETIRE;
          end else if (wd_max) begin
            err_pend <= 1'b1;
            state    <= RETIRE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RETIRE: begin
          req0_done <= ~owner;
          req1_done <= owner;
          req_err   <= err_pend;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: the stimulus side predicts every
// ready/enable/done pulse with its cycle stamp, a negedge monitor checks them.
module tb_i2c_cmd_arbiter;
  localparam int TO = 8;
  localparam int M  = (1 << TO) - 1;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_complete = 1'b0;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_address = 16'h0;
  logic [15:0] req0_data = 16'h0;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_address = 16'h0;
  logic [15:0] req1_data = 16'h0;
  logic        interface_acknowledge = 1'b0;
  logic        req0_ready, req0_done, req1_ready, req1_done, req_err;
  logic [15:0] i2c_address, i2c_data;
  logic        interface_enable, busy, owner;

  i2c_cmd_arbiter #(.TO_WIDTH(TO)) dut (
    .clk50(clk50), .reset(reset), .cfg_complete(cfg_complete),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_data(req0_data),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_data(req1_data),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .req_err(req_err), .i2c_address(i2c_address), .i2c_data(i2c_data),
    .interface_enable(interface_enable),
    .interface_acknowledge(interface_acknowledge),
    .busy(busy), .owner(owner)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit model_last = 1'b1;

  typedef struct {int cyc; bit id; logic [15:0] a; logic [15:0] d;} rdy_t;
  typedef struct {int cyc; bit id; bit err; logic [15:0] a; logic [15:0] d;} done_t;
  rdy_t  rdy_q[$];
  done_t done_q[$];
  int    en_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_addr", 32'(i2c_address), 0);
    chk("rst_data", 32'(i2c_data), 0);
    chk("rst_flags", 32'({req0_ready, req1_ready, req0_done, req1_done, req_err,
                          interface_enable, busy, owner}), 0);
  endtask

  rdy_t  m_r;
  done_t m_d;
  int    m_e;

  // Monitor: pop and compare whenever the DUT presents a pulse.
  always @(negedge clk50) begin
    if (reset) begin
      while (rdy_q.size() > 0 && rdy_q[0].cyc < cyc) begin
        m_r = rdy_q.pop_front();
        chk("ready_missing_cycle", cyc, m_r.cyc);
      end
      while (en_q.size() > 0 && en_q[0] < cyc) begin
        m_e = en_q.pop_front();
        chk("enable_missing_cycle", cyc, m_e);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        m_d = done_q.pop_front();
        chk("done_missing_cycle", cyc, m_d.cyc);
      end
      if (req0_ready | req1_ready) begin
        if (rdy_q.size() == 0) chk("ready_unexpected", 32'({req0_ready, req1_ready}), 0);
        else begin
          m_r = rdy_q.pop_front();
          chk("ready_cycle", cyc, m_r.cyc);
          chk("ready_both", 32'(req0_ready & req1_ready), 0);
          chk("ready_id", 32'(req1_ready), 32'(m_r.id));
          chk("ready_addr", 32'(i2c_address), 32'(m_r.a));
          chk("ready_data", 32'(i2c_data), 32'(m_r.d));
          chk("ready_owner", 32'(owner), 32'(m_r.id));
          chk("ready_busy", 32'(busy), 1);
        end
      end
      if (interface_enable) begin
        if (en_q.size() == 0) chk("enable_unexpected", 32'(interface_enable), 0);
        else begin
          m_e = en_q.pop_front();
          chk("enable_cycle", cyc, m_e);
        end
      end
      if (req0_done | req1_done) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'({req0_done, req1_done}), 0);
        else begin
          m_d = done_q.pop_front();
          chk("done_cycle", cyc, m_d.cyc);
          chk("done_both", 32'(req0_done & req1_done), 0);
          chk("done_id", 32'(req1_done), 32'(m_d.id));
          chk("done_err", 32'(req_err), 32'(m_d.err));
          chk("done_busy", 32'(busy), 0);
          chk("done_addr_hold", 32'(i2c_address), 32'(m_d.a));
          chk("done_data_hold", 32'(i2c_data), 32'(m_d.d));
        end
      end else if (req_err) begin
        chk("err_without_done", 32'(req_err), 0);
      end
    end
  end

  // Present requests at the current negedge and predict the grant.
  task automatic start_txn(input bit v0, input bit v1, input bit cfg,
                           input logic [15:0] a0, input logic [15:0] d0,
                           input logic [15:0] a1, input logic [15:0] d1,
                           output bit w, output logic [15:0] wa,
                           output logic [15:0] wdat, output int c);
    bit e0, e1;
    cfg_complete = cfg;
    req0_valid = v0; req0_address = a0; req0_data = d0;
    req1_valid = v1; req1_address = a1; req1_data = d1;
    c  = cyc;
    e0 = v0;
    e1 = v1 & cfg;
    if (e0 && e1) w = ~model_last;
    else w = e1;
    model_last = w;
    wa   = w ? a1 : a0;
    wdat = w ? d1 : d0;
    rdy_q.push_back('{c + 1, w, wa, wdat});
    @(negedge clk50);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_address = 16'($urandom); req0_data = 16'($urandom);
    req1_address = 16'($urandom); req1_data = 16'($urandom);
  endtask

  // Drive the master handshake. rise_dly<=0 means the master never answers.
  task automatic finish_txn(input bit w, input logic [15:0] wa, input logic [15:0] wdat,
                            input int c, input int rise_dly, input int fall_dly,
                            input bit glitch);
    int r, f, done_c;
    bit err;
    if (rise_dly <= 0) begin
      done_c = c + M + 3;
      done_q.push_back('{done_c, w, 1'b1, wa, wdat});
      while (cyc < done_c) @(negedge clk50);
    end else begin
      while (cyc < c + rise_dly) @(negedge clk50);
      r = cyc;
      interface_acknowledge = 1'b1;
      en_q.push_back(r + 1);
      f = r + fall_dly;
      if (fall_dly <= M + 1) begin done_c = f + 2; err = 1'b0; end
      else begin done_c = r + M + 3; err = 1'b1; end
      done_q.push_back('{done_c, w, err, wa, wdat});
      while (cyc < f) begin
        @(negedge clk50);
        if (glitch && cyc == r + 1 && f > r + 2) begin
          #2 interface_acknowledge = 1'b0;
          #2 interface_acknowledge = 1'b1;
        end
      end
      interface_acknowledge = 1'b0;
      while (cyc < done_c) @(negedge clk50);
    end
  endtask

  task automatic idle_gap(input int n, input bit toggle);
    if (toggle) begin
      interface_acknowledge = 1'b1;
      @(negedge clk50);
      interface_acknowledge = 1'b0;
      @(negedge clk50);
    end
    repeat (n) @(negedge clk50);
  endtask

  initial begin
    #(20 * 30000);
    $display("FAIL global_timeout: cycle %0d limit 30000", cyc);
    $fatal(1);
  end

  initial begin
    bit w, v0, v1, cf;
    logic [15:0] wa, wdat;
    int c;

    reset = 1'b0;
    repeat (3) @(negedge clk50);
    chk_reset_outputs();
    reset = 1'b1;
    @(negedge clk50);

    // Basic accept/issue/retire from the sequencer.
    start_txn(1, 0, 0, 16'h0032, 16'h739b, 16'h1111, 16'h2222, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 10, 200, 0);

    // Requester 1 locked out until cfg_complete.
    cfg_complete = 1'b0;
    req1_valid = 1'b1; req1_address = 16'h0022; req1_data = 16'h5a5a;
    repeat (500) @(negedge clk50);
    start_txn(0, 1, 1, 16'h0, 16'h0, 16'h0022, 16'h5a5a, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 4, 8, 0);

    // Round-robin ties.
    for (int i = 0; i < 4; i++) begin
      start_txn(1, 1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                w, wa, wdat, c);
      finish_txn(w, wa, wdat, c, $urandom_range(1, 8), $urandom_range(1, 20), 1);
    end

    // Timeout before rise, then a normal command is still accepted.
    start_txn(1, 0, 1, 16'h00a5, 16'hbeef, 16'h0, 16'h0, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 0, 0, 0);
    start_txn(0, 1, 1, 16'h0, 16'h0, 16'h0044, 16'h1234, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 3, 5, 0);

    // Fall on the watchdog's terminal cycle wins; a later fall times out.
    start_txn(1, 1, 1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 3, M + 1, 0);
    start_txn(1, 1, 1, 16'h0505, 16'h0606, 16'h0707, 16'h0808, w, wa, wdat, c);
    finish_txn(w, wa, wdat, c, 2, M + 45, 0);

    // Reset in WAIT_FALL aborts silently; the later fall gets no response.
    start_txn(1, 1, 1, 16'h0909, 16'h0a0a, 16'h0b0b, 16'h0c0c, w, wa, wdat, c);
    while (cyc < c + 2) @(negedge clk50);
    interface_acknowledge = 1'b1;
    en_q.push_back(cyc + 1);
    repeat (4) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);
    reset = 1'b1;
    model_last = 1'b1;
    chk_reset_outputs();
    repeat (5) @(negedge clk50);
    interface_acknowledge = 1'b0;
    repeat (30) @(negedge clk50);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      idle_gap($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      cf = 1'($urandom_range(0, 1));
      if (!(v0 || (v1 && cf))) v0 = 1'b1;
      start_txn(v0, v1, cf, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                w, wa, wdat, c);
      if ($urandom_range(0, 9) == 0)
        finish_txn(w, wa, wdat, c, 0, 0, 0);
      else
        finish_txn(w, wa, wdat, c, $urandom_range(1, 12), $urandom_range(1, 40),
                   1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk50);
    chk("ready_queue_drained", rdy_q.size(), 0);
    chk("enable_queue_drained", en_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
